// File: rtl/riscv_fetch_pkg.sv
// Shared types for the fetch sequencer: queue entry layout and counter sizing.
package riscv_fetch_pkg;

  localparam int FETCH_XLEN   = 32;
  localparam int FETCH_PARCEL = 32;

  typedef struct packed {
    logic [FETCH_PARCEL-1:0] parcel;
    logic [FETCH_XLEN-1:0]   pc;
    logic                    misaligned;
    logic                    err;
  } fetch_entry_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/riscv_fetch_seq_if.sv
// Instruction bus seen from the fetch sequencer: request/accept plus in-order read responses.
interface riscv_fetch_seq_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32
);
  logic                   ibus_req;
  logic [XLEN-1:0]        ibus_adr;
  logic                   ibus_ack;
  logic                   ibus_rvalid;
  logic [PARCEL_SIZE-1:0] ibus_rdata;
  logic                   ibus_err;

  modport master (output ibus_req, ibus_adr, input ibus_ack, ibus_rvalid, ibus_rdata, ibus_err);
  modport slave  (input ibus_req, ibus_adr, output ibus_ack, ibus_rvalid, ibus_rdata, ibus_err);
endinterface

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO with registered storage and a flush that empties it in one cycle.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_din,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_dout,
  output logic [cnt_w(DEPTH)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_do_push = i_push & (~w_full | i_pop);
  assign w_do_pop  = i_pop & ~w_empty;
  assign o_dout    = r_mem[r_rd];
  assign o_count   = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/riscv_fetch_seq.sv
// Fetch sequencer: issues word fetches, tracks live and killed requests, queues parcels for IF.
module riscv_fetch_seq
  import riscv_fetch_pkg::*;
#(
  parameter int XLEN            = FETCH_XLEN,
  parameter int PARCEL_SIZE     = FETCH_PARCEL,
  parameter int QUEUE_DEPTH     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  riscv_fetch_seq_if.master         ibus
);

  localparam int OW = cnt_w(MAX_OUTSTANDING);
  localparam int QW = cnt_w(QUEUE_DEPTH);
  localparam int SW = cnt_w(2 * (QUEUE_DEPTH + MAX_OUTSTANDING));

  logic [OW-1:0] r_live;
  logic [OW-1:0] r_kill;
  logic [QW-1:0] w_q_cnt;
  logic [OW-1:0] w_pc_cnt;
  logic [XLEN-1:0] w_pc_head;
  fetch_entry_t  w_q_din;
  fetch_entry_t  w_q_head;
  logic w_aligned, w_credit, w_accept, w_mis_push;
  logic w_rsp_any, w_rsp_kill, w_rsp_live;
  logic w_q_empty, w_q_full, w_q_push, w_q_pop;

  assign w_q_empty = (w_q_cnt == '0);
  assign w_q_full  = (w_q_cnt == QW'(QUEUE_DEPTH));
  assign w_aligned = (if_nxt_pc[1:0] == 2'b00);
  // Killed requests still hold bus slots until their responses drain.
  assign w_credit  = (SW'(r_live) + SW'(w_q_cnt) < SW'(QUEUE_DEPTH)) &
                     (SW'(r_live) + SW'(r_kill)  < SW'(MAX_OUTSTANDING));

  assign ibus.ibus_req = w_credit & ~if_flush & w_aligned & ~rst;
  assign ibus.ibus_adr = if_nxt_pc;
  assign w_accept      = ibus.ibus_req & ibus.ibus_ack;
  assign w_mis_push    = ~w_aligned & ~if_flush & ~rst & (r_live == '0) & ~w_q_full;
  assign if_stall_nxt_pc = ~(w_accept | w_mis_push);

  assign w_rsp_any  = ibus.ibus_rvalid & ((r_live != '0) | (r_kill != '0));
  assign w_rsp_kill = ibus.ibus_rvalid & (r_kill != '0);
  assign w_rsp_live = ibus.ibus_rvalid & (r_kill == '0) & (w_pc_cnt != '0) & ~if_flush;

  always_comb begin
    w_q_din = '0;
    if (w_rsp_live) begin
      w_q_din.parcel = ibus.ibus_rdata;
      w_q_din.pc     = w_pc_head;
      w_q_din.err    = ibus.ibus_err;
    end else begin
      w_q_din.pc         = if_nxt_pc;
      w_q_din.misaligned = 1'b1;
    end
  end

  // Live responses and misaligned pushes are exclusive: the latter needs live_cnt==0.
  assign w_q_push = w_rsp_live | w_mis_push;
  assign w_q_pop  = ~w_q_empty & ~if_stall & ~if_flush;

  riscv_fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (if_flush),
    .i_push  (w_accept),
    .i_din   (if_nxt_pc),
    .i_pop   (w_rsp_live),
    .o_dout  (w_pc_head),
    .o_count (w_pc_cnt)
  );

  riscv_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QUEUE_DEPTH)) u_rsp_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (if_flush),
    .i_push  (w_q_push),
    .i_din   (w_q_din),
    .i_pop   (w_q_pop),
    .o_dout  (w_q_head),
    .o_count (w_q_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_live <= '0;
      r_kill <= '0;
    end else if (if_flush) begin
      r_kill <= r_kill + r_live - OW'(w_rsp_any);
      r_live <= '0;
    end else begin
      r_kill <= r_kill - OW'(w_rsp_kill);
      if (w_accept && !w_rsp_live)      r_live <= r_live + 1'b1;
      else if (!w_accept && w_rsp_live) r_live <= r_live - 1'b1;
    end
  end

  assign if_parcel_valid      = {(PARCEL_SIZE/16){~w_q_empty}};
  assign if_parcel            = w_q_empty ? '0 : w_q_head.parcel;
  assign if_parcel_pc         = w_q_empty ? '0 : w_q_head.pc;
  assign if_parcel_misaligned = ~w_q_empty & w_q_head.misaligned;
  assign if_parcel_page_fault = ~w_q_empty & w_q_head.err;

endmodule
